// File: rtl/sw_multi_engine_dispatch.sv
// Front-end dispatcher for a bank of Smith-Waterman engines.
// The query path hands host query info and query blocks round-robin to idle engines.
// The reference path time-multiplexes engine read requests onto one DRAM reader
// and steers the returned blocks back to the requesting engine.
module sw_multi_engine_dispatch #(
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W   = 2,
  parameter int NUM_PES     = 64,
  parameter int REF_LENGTH  = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [24:0]                   ref_length_in,
  input  logic [24:0]                   ref_addr_in,
  input  logic [15:0]                   num_query_blocks_in,
  input  logic [15:0]                   query_id_in,
  input  logic [31:0]                   cell_score_threshold_in,
  input  logic                          query_info_valid_in,
  output logic                          query_info_rdy_out,
  input  logic [2*NUM_PES-1:0]          query_seq_block_in,
  input  logic                          query_seq_block_valid_in,
  output logic                          query_seq_block_rdy_out,
  output logic [24:0]                   eng_ref_length_out,
  output logic [24:0]                   eng_ref_addr_out,
  output logic [15:0]                   eng_num_query_blocks_out,
  output logic [15:0]                   eng_query_id_out,
  output logic [31:0]                   eng_cell_score_threshold_out,
  output logic [NUM_ENGINES-1:0]        eng_query_info_valid_out,
  input  logic [NUM_ENGINES-1:0]        eng_query_info_rdy_in,
  output logic [2*NUM_PES-1:0]          eng_query_seq_block_out,
  output logic [NUM_ENGINES-1:0]        eng_query_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]        eng_query_seq_block_rdy_in,
  input  logic [25*NUM_ENGINES-1:0]     eng_ref_addr_in,
  input  logic [25*NUM_ENGINES-1:0]     eng_ref_length_in,
  input  logic [NUM_ENGINES-1:0]        eng_ref_info_valid_in,
  output logic [NUM_ENGINES-1:0]        eng_ref_done_out,
  output logic [24:0]                   ref_addr_out,
  output logic [24:0]                   ref_length_out,
  output logic                          ref_info_valid_out,
  input  logic                          ref_info_rdy_in,
  input  logic [2*REF_LENGTH-1:0]       ref_seq_block_in,
  input  logic                          ref_seq_block_valid_in,
  output logic                          ref_seq_block_rdy_out,
  output logic [2*REF_LENGTH-1:0]       eng_ref_seq_block_out,
  output logic [NUM_ENGINES-1:0]        eng_ref_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]        eng_ref_seq_block_rdy_in,
  output logic [ENG_IDX_W-1:0]          q_target_out
);

  typedef enum logic {Q_IDLE, Q_BLOCKS} q_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_STREAM} r_state_t;

  q_state_t             q_state;
  logic [ENG_IDX_W-1:0] q_rr;
  logic [ENG_IDX_W-1:0] q_target;
  logic [15:0]          q_left;

  r_state_t             r_state;
  logic [ENG_IDX_W-1:0] r_rr;
  logic [ENG_IDX_W-1:0] r_grant;
  logic [24:0]          r_addr;
  logic [24:0]          r_len;
  logic [24:0]          r_left;
  logic                 done_pend;

  logic                 active;
  logic                 q_found;
  logic [ENG_IDX_W-1:0] q_idx;
  logic                 r_found;
  logic [ENG_IDX_W-1:0] r_idx;
  logic                 r_take;
  logic                 q_info_xfer;
  logic                 q_blk_xfer;
  logic                 r_blk_xfer;

  // Returns {found, index} of the first requester at or after rr, wrapping.
  function automatic logic [ENG_IDX_W:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                                 input logic [ENG_IDX_W-1:0] rr);
    logic                 found;
    logic [ENG_IDX_W-1:0] idx;
    int                   i;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      i = (int'(rr) + k) % NUM_ENGINES;
      if (req[i]) begin
        found = 1'b1;
        idx   = ENG_IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  // Engine index following i, modulo NUM_ENGINES.
  function automatic logic [ENG_IDX_W-1:0] next_idx(input logic [ENG_IDX_W-1:0] i);
    if (int'(i) == NUM_ENGINES - 1) return '0;
    return i + 1'b1;
  endfunction

  assign active = !stall && !rst;
  assign {q_found, q_idx} = rr_pick(eng_query_info_rdy_in, q_rr);
  assign {r_found, r_idx} = rr_pick(eng_ref_info_valid_in, r_rr);
  // A finishing engine still holds its request during the done pulse, so hold off arbitration.
  assign r_take = (r_state == R_IDLE) && r_found && !done_pend;

  assign eng_ref_length_out           = ref_length_in;
  assign eng_ref_addr_out             = ref_addr_in;
  assign eng_num_query_blocks_out     = num_query_blocks_in;
  assign eng_query_id_out             = query_id_in;
  assign eng_cell_score_threshold_out = cell_score_threshold_in;
  assign eng_query_seq_block_out      = query_seq_block_in;
  assign eng_ref_seq_block_out        = ref_seq_block_in;
  assign ref_addr_out                 = r_addr;
  assign ref_length_out               = r_len;
  assign q_target_out                 = q_target;

  assign q_info_xfer = query_info_valid_in && query_info_rdy_out;
  assign q_blk_xfer  = query_seq_block_valid_in && query_seq_block_rdy_out;
  assign r_blk_xfer  = ref_seq_block_valid_in && ref_seq_block_rdy_out;

  // Handshake routing for both paths; everything is forced low while stalled or in reset.
  always_comb begin
    query_info_rdy_out            = 1'b0;
    eng_query_info_valid_out      = '0;
    query_seq_block_rdy_out       = 1'b0;
    eng_query_seq_block_valid_out = '0;
    ref_info_valid_out            = 1'b0;
    ref_seq_block_rdy_out         = 1'b0;
    eng_ref_seq_block_valid_out   = '0;
    eng_ref_done_out              = '0;
    if (active) begin
      if (q_state == Q_IDLE) begin
        if (q_found) begin
          query_info_rdy_out              = 1'b1;
          eng_query_info_valid_out[q_idx] = query_info_valid_in;
        end
      end else begin
        eng_query_seq_block_valid_out[q_target] = query_seq_block_valid_in;
        query_seq_block_rdy_out                 = eng_query_seq_block_rdy_in[q_target];
      end
      if (r_state == R_REQ) ref_info_valid_out = 1'b1;
      if (r_state == R_STREAM) begin
        eng_ref_seq_block_valid_out[r_grant] = ref_seq_block_valid_in;
        ref_seq_block_rdy_out                = eng_ref_seq_block_rdy_in[r_grant];
      end
      if (done_pend) eng_ref_done_out[r_grant] = 1'b1;
    end
  end

  // Query FSM: pick an idle engine for the info, then feed it the block count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_state  <= Q_IDLE;
      q_rr     <= '0;
      q_target <= '0;
      q_left   <= '0;
    end else if (!stall) begin
      case (q_state)
        Q_IDLE: begin
          if (q_info_xfer) begin
            q_target <= q_idx;
            q_left   <= num_query_blocks_in;
            if (num_query_blocks_in == 16'd0) q_rr <= next_idx(q_idx);
            else                              q_state <= Q_BLOCKS;
          end
        end
        default: begin
          if (q_blk_xfer) begin
            q_left <= q_left - 16'd1;
            if (q_left == 16'd1) begin
              q_state <= Q_IDLE;
              q_rr    <= next_idx(q_target);
            end
          end
        end
      endcase
    end
  end

  // Reference FSM control: arbitrate, issue the DRAM request, count the stream, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_left    <= '0;
      done_pend <= 1'b0;
    end else if (!stall) begin
      if (done_pend) done_pend <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (r_take) begin
            r_grant <= r_idx;
            r_state <= R_REQ;
          end
        end
        R_REQ: begin
          if (ref_info_rdy_in) begin
            r_left <= r_len;
            if (r_len == 25'd0) begin
              done_pend <= 1'b1;
              r_rr      <= next_idx(r_grant);
              r_state   <= R_IDLE;
            end else begin
              r_state <= R_STREAM;
            end
          end
        end
        R_STREAM: begin
          if (r_blk_xfer) begin
            r_left <= r_left - 25'd1;
            if (r_left == 25'd1) begin
              done_pend <= 1'b1;
              r_rr      <= next_idx(r_grant);
              r_state   <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Latch the granted engine's request address and length.
  always_ff @(posedge clk) begin
    if (!stall && !rst && r_take) begin
      r_addr <= eng_ref_addr_in[25*r_idx +: 25];
      r_len  <= eng_ref_length_in[25*r_idx +: 25];
    end
  end

endmodule

// File: tb/tb_sw_multi_engine_dispatch.sv
// Directed bench for sw_multi_engine_dispatch with four engines.
module tb_sw_multi_engine_dispatch;

  localparam int N   = 4;
  localparam int QBW = 128;
  localparam int RBW = 256;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stall = 1'b0;
  logic [24:0]    ref_length_in = '0;
  logic [24:0]    ref_addr_in = '0;
  logic [15:0]    num_query_blocks_in = '0;
  logic [15:0]    query_id_in = '0;
  logic [31:0]    cell_score_threshold_in = '0;
  logic           query_info_valid_in = 1'b0;
  logic           query_info_rdy_out;
  logic [QBW-1:0] query_seq_block_in = '0;
  logic           query_seq_block_valid_in = 1'b0;
  logic           query_seq_block_rdy_out;
  logic [24:0]    eng_ref_length_out;
  logic [24:0]    eng_ref_addr_out;
  logic [15:0]    eng_num_query_blocks_out;
  logic [15:0]    eng_query_id_out;
  logic [31:0]    eng_cell_score_threshold_out;
  logic [N-1:0]   eng_query_info_valid_out;
  logic [N-1:0]   eng_query_info_rdy_in = 4'hF;
  logic [QBW-1:0] eng_query_seq_block_out;
  logic [N-1:0]   eng_query_seq_block_valid_out;
  logic [N-1:0]   eng_query_seq_block_rdy_in = 4'hF;
  logic [25*N-1:0] eng_ref_addr_in = '0;
  logic [25*N-1:0] eng_ref_length_in = '0;
  logic [N-1:0]   eng_ref_info_valid_in = '0;
  logic [N-1:0]   eng_ref_done_out;
  logic [24:0]    ref_addr_out;
  logic [24:0]    ref_length_out;
  logic           ref_info_valid_out;
  logic           ref_info_rdy_in = 1'b0;
  logic [RBW-1:0] ref_seq_block_in = '0;
  logic           ref_seq_block_valid_in = 1'b0;
  logic           ref_seq_block_rdy_out;
  logic [RBW-1:0] eng_ref_seq_block_out;
  logic [N-1:0]   eng_ref_seq_block_valid_out;
  logic [N-1:0]   eng_ref_seq_block_rdy_in = 4'hF;
  logic [1:0]     q_target_out;

  int n_checks = 0;
  int n_fail   = 0;
  int          qblk_cnt [N] = '{default: 0};
  int          rblk_cnt [N] = '{default: 0};
  int          done_cnt [N] = '{default: 0};
  logic [31:0] rblk_sum [N] = '{default: 32'd0};

  sw_multi_engine_dispatch #(.NUM_ENGINES(N), .ENG_IDX_W(2), .NUM_PES(64), .REF_LENGTH(128)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ref_length_in(ref_length_in), .ref_addr_in(ref_addr_in),
    .num_query_blocks_in(num_query_blocks_in), .query_id_in(query_id_in),
    .cell_score_threshold_in(cell_score_threshold_in),
    .query_info_valid_in(query_info_valid_in), .query_info_rdy_out(query_info_rdy_out),
    .query_seq_block_in(query_seq_block_in), .query_seq_block_valid_in(query_seq_block_valid_in),
    .query_seq_block_rdy_out(query_seq_block_rdy_out),
    .eng_ref_length_out(eng_ref_length_out), .eng_ref_addr_out(eng_ref_addr_out),
    .eng_num_query_blocks_out(eng_num_query_blocks_out), .eng_query_id_out(eng_query_id_out),
    .eng_cell_score_threshold_out(eng_cell_score_threshold_out),
    .eng_query_info_valid_out(eng_query_info_valid_out), .eng_query_info_rdy_in(eng_query_info_rdy_in),
    .eng_query_seq_block_out(eng_query_seq_block_out),
    .eng_query_seq_block_valid_out(eng_query_seq_block_valid_out),
    .eng_query_seq_block_rdy_in(eng_query_seq_block_rdy_in),
    .eng_ref_addr_in(eng_ref_addr_in), .eng_ref_length_in(eng_ref_length_in),
    .eng_ref_info_valid_in(eng_ref_info_valid_in), .eng_ref_done_out(eng_ref_done_out),
    .ref_addr_out(ref_addr_out), .ref_length_out(ref_length_out),
    .ref_info_valid_out(ref_info_valid_out), .ref_info_rdy_in(ref_info_rdy_in),
    .ref_seq_block_in(ref_seq_block_in), .ref_seq_block_valid_in(ref_seq_block_valid_in),
    .ref_seq_block_rdy_out(ref_seq_block_rdy_out),
    .eng_ref_seq_block_out(eng_ref_seq_block_out),
    .eng_ref_seq_block_valid_out(eng_ref_seq_block_valid_out),
    .eng_ref_seq_block_rdy_in(eng_ref_seq_block_rdy_in),
    .q_target_out(q_target_out)
  );

  always #5 clk = ~clk;

  // Count completed engine-side transfers and done pulses at each clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!stall && !rst) begin
        if (eng_query_seq_block_valid_out[i] && eng_query_seq_block_rdy_in[i])
          qblk_cnt[i] <= qblk_cnt[i] + 1;
        if (eng_ref_seq_block_valid_out[i] && eng_ref_seq_block_rdy_in[i]) begin
          rblk_cnt[i] <= rblk_cnt[i] + 1;
          rblk_sum[i] <= rblk_sum[i] + eng_ref_seq_block_out[31:0];
        end
      end
      if (eng_ref_done_out[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int g);
    return 64'(1) << g;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one query info, expect it on engine t, then push its blocks.
  task automatic send_query(input int nblk, input logic [15:0] id, input int t);
    query_info_valid_in = 1'b1;
    num_query_blocks_in = 16'(nblk);
    query_id_in         = id;
    #1;
    chk("qinfo_rdy", 64'(query_info_rdy_out), 64'd1);
    chk("qinfo_route", 64'(eng_query_info_valid_out), oh(t));
    chk("qid_bcast", 64'(eng_query_id_out), 64'(id));
    cyc();
    query_info_valid_in = 1'b0;
    chk("q_target", 64'(q_target_out), 64'(t));
    for (int b = 0; b < nblk; b++) begin
      query_seq_block_valid_in = 1'b1;
      query_seq_block_in = QBW'({id, 16'(b)});
      #1;
      chk("qblk_route", 64'(eng_query_seq_block_valid_out), oh(t));
      chk("qblk_rdy", 64'(query_seq_block_rdy_out), 64'd1);
      chk("qinfo_busy", 64'(query_info_rdy_out), 64'd0);
      cyc();
    end
    query_seq_block_valid_in = 1'b0;
    #1;
    chk("q_back_idle", 64'(query_info_rdy_out), 64'd1);
  endtask

  // Stream n blocks to engine g under per-cycle ready/stall patterns, then check the done pulse.
  task automatic ref_stream(input int n, input int g, input logic [31:0] base,
                            input logic [15:0] rdy_pat, input logic [15:0] stall_pat);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < n && c < 40) begin
      stall = stall_pat[c % 16];
      eng_ref_seq_block_rdy_in[g] = rdy_pat[c % 16];
      ref_seq_block_in = RBW'(base + 32'(k));
      ref_seq_block_valid_in = 1'b1;
      #1;
      if (stall) begin
        chk("stall_outs", 64'({eng_ref_seq_block_valid_out, ref_seq_block_rdy_out, eng_ref_done_out,
                               query_info_rdy_out, ref_info_valid_out, eng_query_info_valid_out}), 64'd0);
      end else begin
        chk("rblk_route", 64'(eng_ref_seq_block_valid_out), oh(g));
        chk("rblk_rdy", 64'(ref_seq_block_rdy_out), 64'(rdy_pat[c % 16]));
        chk("rblk_data", 64'(eng_ref_seq_block_out), 64'(base + 32'(k)));
        if (rdy_pat[c % 16]) k++;
      end
      cyc();
      c++;
    end
    stall = 1'b0;
    eng_ref_seq_block_rdy_in = 4'hF;
    ref_seq_block_valid_in = 1'b0;
    if (k < n) chk("rstream_timeout", 64'(k), 64'(n));
    stall = 1'b1;
    #1;
    chk("done_held_in_stall", 64'(eng_ref_done_out), 64'd0);
    cyc();
    stall = 1'b0;
    #1;
    chk("done_pulse", 64'(eng_ref_done_out), oh(g));
    cyc();
    eng_ref_info_valid_in[g] = 1'b0;
    chk("done_one_cycle", 64'(eng_ref_done_out), 64'd0);
  endtask

  task automatic set_ref(input int g, input logic [24:0] addr, input logic [24:0] len);
    eng_ref_addr_in[25*g +: 25]   = addr;
    eng_ref_length_in[25*g +: 25] = len;
    eng_ref_info_valid_in[g]      = 1'b1;
  endtask

  initial begin
    // Reset: outputs low while held, idle afterwards with pointer at engine 0.
    cyc();
    cyc();
    chk("rst_qinfo_rdy", 64'(query_info_rdy_out), 64'd0);
    chk("rst_ref_valid", 64'(ref_info_valid_out), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_qinfo_rdy", 64'(query_info_rdy_out), 64'd1);
    chk("post_rst_qtarget", 64'(q_target_out), 64'd0);
    chk("post_rst_done", 64'(eng_ref_done_out), 64'd0);

    // Round-robin query distribution, two blocks each.
    send_query(2, 16'h0A00, 0);
    send_query(2, 16'h0A01, 1);
    send_query(2, 16'h0A02, 2);
    chk("qblk_cnt0", 64'(qblk_cnt[0]), 64'd2);
    chk("qblk_cnt1", 64'(qblk_cnt[1]), 64'd2);
    chk("qblk_cnt2", 64'(qblk_cnt[2]), 64'd2);
    chk("qblk_cnt3", 64'(qblk_cnt[3]), 64'd0);

    // Zero-block queries advance the pointer to 1, then engine 1 busy steers to engine 2.
    send_query(0, 16'h0B03, 3);
    send_query(0, 16'h0B00, 0);
    eng_query_info_rdy_in = 4'b1101;
    send_query(1, 16'h0C02, 2);
    eng_query_info_rdy_in = 4'hF;
    send_query(0, 16'h0C03, 3);
    chk("qblk_cnt2_after", 64'(qblk_cnt[2]), 64'd3);
    chk("qblk_cnt3_after", 64'(qblk_cnt[3]), 64'd0);

    // Engines 0 and 3 request together; engine 0 wins first.
    set_ref(0, 25'h100, 25'd3);
    set_ref(3, 25'h300, 25'd2);
    cyc();
    chk("req0_valid", 64'(ref_info_valid_out), 64'd1);
    chk("req0_addr", 64'(ref_addr_out), 64'h100);
    chk("req0_len", 64'(ref_length_out), 64'd3);
    cyc();
    chk("req0_hold", 64'(ref_info_valid_out), 64'd1);
    ref_info_rdy_in = 1'b1;
    cyc();
    ref_info_rdy_in = 1'b0;
    chk("req0_dropped", 64'(ref_info_valid_out), 64'd0);
    ref_stream(3, 0, 32'h1000, 16'hFFFF, 16'h0000);
    chk("rblk_cnt0", 64'(rblk_cnt[0]), 64'd3);
    chk("rblk_sum0", 64'(rblk_sum[0]), 64'h3003);
    cyc();
    chk("req3_addr", 64'(ref_addr_out), 64'h300);
    chk("req3_len", 64'(ref_length_out), 64'd2);
    ref_info_rdy_in = 1'b1;
    cyc();
    ref_info_rdy_in = 1'b0;
    ref_stream(2, 3, 32'h3000, 16'hFFFF, 16'h0000);
    chk("rblk_cnt3", 64'(rblk_cnt[3]), 64'd2);
    chk("rblk_sum3", 64'(rblk_sum[3]), 64'h6001);
    chk("done_cnt0", 64'(done_cnt[0]), 64'd1);
    chk("done_cnt3", 64'(done_cnt[3]), 64'd1);

    // Engine 1 stream with toggling ready and a two-cycle stall.
    set_ref(1, 25'h200, 25'd4);
    cyc();
    chk("req1_addr", 64'(ref_addr_out), 64'h200);
    ref_info_rdy_in = 1'b1;
    cyc();
    ref_info_rdy_in = 1'b0;
    ref_stream(4, 1, 32'h2000, 16'hFEDD, 16'h000C);
    chk("rblk_cnt1", 64'(rblk_cnt[1]), 64'd4);
    chk("rblk_sum1", 64'(rblk_sum[1]), 64'h8006);
    chk("done_cnt1", 64'(done_cnt[1]), 64'd1);

    // Zero-length reference request: accepted, done next cycle, no blocks.
    set_ref(2, 25'h0AA, 25'd0);
    cyc();
    chk("req2_len0", 64'(ref_length_out), 64'd0);
    ref_info_rdy_in = 1'b1;
    cyc();
    ref_info_rdy_in = 1'b0;
    chk("done2_zero_len", 64'(eng_ref_done_out), oh(2));
    cyc();
    eng_ref_info_valid_in[2] = 1'b0;
    chk("done2_cleared", 64'(eng_ref_done_out), 64'd0);
    chk("rblk_cnt2", 64'(rblk_cnt[2]), 64'd0);
    chk("ref_idle_after0", 64'(ref_info_valid_out), 64'd0);

    // Reset in mid stream with five blocks remaining.
    send_query(0, 16'h0D00, 0);
    set_ref(0, 25'h500, 25'd7);
    cyc();
    chk("req_rst_addr", 64'(ref_addr_out), 64'h500);
    ref_info_rdy_in = 1'b1;
    cyc();
    ref_info_rdy_in = 1'b0;
    ref_seq_block_valid_in = 1'b1;
    cyc();
    cyc();
    chk("rblk_cnt0_pre_rst", 64'(rblk_cnt[0]), 64'd5);
    rst = 1'b1;
    cyc();
    chk("rst_outs", 64'({eng_ref_seq_block_valid_out, ref_seq_block_rdy_out, eng_ref_done_out,
                         query_info_rdy_out, ref_info_valid_out, eng_query_info_valid_out}), 64'd0);
    chk("rst_qtarget", 64'(q_target_out), 64'd0);
    eng_ref_info_valid_in = '0;
    ref_seq_block_valid_in = 1'b0;
    rst = 1'b0;
    cyc();
    chk("rst_no_done", 64'(eng_ref_done_out), 64'd0);
    chk("rst_ref_idle", 64'(ref_info_valid_out), 64'd0);
    chk("rst_done_cnt0", 64'(done_cnt[0]), 64'd1);
    send_query(0, 16'h0E00, 0);
    set_ref(0, 25'h100, 25'd3);
    set_ref(3, 25'h300, 25'd2);
    cyc();
    chk("rst_rr_ref", 64'(ref_addr_out), 64'h100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_multi_engine_dispatch.md
Name: sw_multi_engine_dispatch

Overview:
Front-end dispatcher for a bank of NUM_ENGINES Smith-Waterman engine units (controller plus systolic array). It distributes host query bookkeeping and query blocks round-robin to idle engines. It also time-multiplexes the engines' reference-read requests onto the single DRAM reference reader, routing each returned reference block to the requesting engine. It sits between the PCIe handler and DRAM reader on one side and the engine array on the other.

Parameters:
NUM_ENGINES, 4, number of engine units served (2..16)
ENG_IDX_W, 2, engine index width; NUM_ENGINES <= 2**ENG_IDX_W
NUM_PES, 64, PEs per engine; query block = 2*NUM_PES bits
REF_LENGTH, 128, chars per reference block; ref block = 2*REF_LENGTH bits

Ports:
clk  in  1  system clock
rst  in  1  reset
stall  in  1  pipeline stall
ref_length_in  in  25  host query info: reference length in blocks
ref_addr_in  in  25  host query info: DRAM reference start address
num_query_blocks_in  in  16  host query info: query length in blocks
query_id_in  in  16  host query info: query ID
cell_score_threshold_in  in  32  host query info: report threshold
query_info_valid_in  in  1  host query info valid
query_info_rdy_out  out  1  host query info accepted
query_seq_block_in  in  2*NUM_PES  host query block
query_seq_block_valid_in  in  1  host query block valid
query_seq_block_rdy_out  out  1  host query block accepted
eng_ref_length_out, eng_ref_addr_out, eng_num_query_blocks_out, eng_query_id_out, eng_cell_score_threshold_out  out  25/25/16/16/32  query info broadcast to all engines
eng_query_info_valid_out  out  NUM_ENGINES  per-engine query info valid
eng_query_info_rdy_in  in  NUM_ENGINES  per-engine query info ready (high = engine idle)
eng_query_seq_block_out  out  2*NUM_PES  query block broadcast
eng_query_seq_block_valid_out  out  NUM_ENGINES  per-engine query block valid
eng_query_seq_block_rdy_in  in  NUM_ENGINES  per-engine query block ready
eng_ref_addr_in  in  25*NUM_ENGINES  per-engine reference address, engine i at [25i+24:25i]
eng_ref_length_in  in  25*NUM_ENGINES  per-engine reference length, same packing
eng_ref_info_valid_in  in  NUM_ENGINES  per-engine reference read request (level)
eng_ref_done_out  out  NUM_ENGINES  one-cycle pulse: engine's reference stream complete
ref_addr_out  out  25  to DRAM reader
ref_length_out  out  25  to DRAM reader
ref_info_valid_out  out  1  DRAM request valid
ref_info_rdy_in  in  1  DRAM request accepted
ref_seq_block_in  in  2*REF_LENGTH  block from DRAM
ref_seq_block_valid_in  in  1  DRAM block valid
ref_seq_block_rdy_out  out  1  DRAM block accepted
eng_ref_seq_block_out  out  2*REF_LENGTH  reference block broadcast
eng_ref_seq_block_valid_out  out  NUM_ENGINES  per-engine reference block valid
eng_ref_seq_block_rdy_in  in  NUM_ENGINES  per-engine reference block ready
q_target_out  out  ENG_IDX_W  engine currently or last targeted by the query path (debug)

Behaviour:
- Clocking: single clock clk; rst is synchronous, active-high.
- Reset: all valid/rdy/done outputs 0; both FSMs idle; both round-robin pointers 0; counters 0; q_target_out 0. Reset mid-transfer abandons it with no done pulse.
- Handshake: a transfer occurs when valid and rdy are both high at a rising edge with stall low. Broadcast data outputs are combinational pass-throughs. Routing is combinational, with no added latency.
- Stall high: all FSM state, counters and pointers hold. All valid and rdy outputs are forced 0. eng_ref_done_out is deferred, not lost.
- Query FSM Q_IDLE:
  - target = first i at or after q_rr (wrapping) with eng_query_info_rdy_in[i]=1.
  - If none: query_info_rdy_out=0.
  - Else: eng_query_info_valid_out[target]=query_info_valid_in and query_info_rdy_out=1.
  - On transfer: latch target and q_left=num_query_blocks_in. Go to Q_BLOCKS, or stay in Q_IDLE with q_rr=target+1 if the count is 0.
- Query FSM Q_BLOCKS:
  - Route valid to the latched target; query_seq_block_rdy_out=eng_query_seq_block_rdy_in[target].
  - Each transfer decrements q_left.
  - The transfer with q_left=1 returns to Q_IDLE and sets q_rr=(target+1) mod NUM_ENGINES.
- Reference FSM R_IDLE: grant = first i at or after r_rr with eng_ref_info_valid_in[i]; latch addr, length and grant, then go to R_REQ.
- Reference FSM R_REQ:
  - ref_info_valid_out=1 with the latched addr/length until ref_info_rdy_in.
  - On accept: r_left=length, go to R_STREAM.
  - If length is 0: pulse done and return to R_IDLE.
- Reference FSM R_STREAM:
  - eng_ref_seq_block_valid_out[grant]=ref_seq_block_valid_in; ref_seq_block_rdy_out=eng_ref_seq_block_rdy_in[grant].
  - The last transfer pulses eng_ref_done_out[grant] on the following cycle, sets r_rr=grant+1, and returns to R_IDLE.
  - Engines drop ref_info_valid the cycle after the done pulse.
- Independence: the query and reference FSMs run concurrently. The same engine may be active in both.

Test Plan:
- 4 engines all ready; 3 queries of 2 blocks each -> query infos go to engines 0, 1, 2 in order; each engine's valid bits see exactly 2 blocks.
- Engine 1 not ready, q_rr=1 -> query goes to engine 2; q_rr becomes 3.
- Engines 0 and 3 request refs of lengths 3 and 2 in the same cycle -> DRAM sees engine 0's addr first; 3 blocks routed to engine 0; done[0] pulses; then engine 3 is granted with 2 blocks and done[3] pulses.
- Ref stream with eng_ref_seq_block_rdy_in[grant] toggling and stall asserted mid-stream -> no block lost or duplicated; all outputs 0 while stalled; r_left frozen.
- num_query_blocks_in=0 and ref_length=0 -> info is accepted, no block phase, the reference done pulses, and the FSMs return to idle.
- rst asserted during R_STREAM with r_left=5 -> next cycle all outputs 0, pointers 0, no done pulse.
